fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the LEGv8 pipeline, directly upstream of the 128-word instruction ROM.
- Holds the PC and drives the ROM word address.
- Captures the returned instruction and its PC into the IF/ID pipeline register.
- Handles stall, branch redirect and exception redirect; exposes a fetched-instruction counter for debug.

Parameters:
N, 64, datapath/PC width in bits
IMEM_AW, 7, instruction-memory word-address width (128 words)
RESET_PC, 64'h0, PC value after reset
EXC_VECTOR, 64'hD8, PC loaded on exception redirect
CNT_W, 32, width of fetched-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
stall_i  input  1  hazard unit stall request: hold PC and IF/ID
branch_taken_i  input  1  branch resolved taken in a later stage
branch_target_i  input  N  branch destination byte address
exc_i  input  1  exception raised in a later stage
imem_addr_o  output  IMEM_AW  ROM word address = pc_o[IMEM_AW+1:2]
imem_q_i  input  32  instruction word from ROM (combinational read)
pc_o  output  N  current fetch PC
if_id_pc_o  output  N  PC of instruction held in IF/ID
if_id_instr_o  output  32  instruction held in IF/ID
if_id_valid_o  output  1  IF/ID holds a real instruction (0 = bubble)
fetch_count_o  output  CNT_W  number of instructions loaded into IF/ID

Behaviour:
- Reset (async, immediate, also mid-operation) drives these values:
  - pc_o = RESET_PC
  - if_id_pc_o = 0
  - if_id_instr_o = 0
  - if_id_valid_o = 0
  - fetch_count_o = 0
- imem_addr_o is purely combinational from pc_o. The ROM read is combinational, so the instruction at pc_o is sampled in the same cycle: one-cycle fetch latency to IF/ID.
- Next-PC priority, highest first:
  1. exc_i: PC <= EXC_VECTOR.
  2. branch_taken_i: PC <= {branch_target_i[N-1:2], 2'b00}. Low bits are forced to zero; there is no misalignment fault.
  3. stall_i: PC holds.
  4. Otherwise PC <= PC + 4, modulo 2^N. No saturation; the ROM address aliases modulo 128 words (PC 0x200 reads word 0).
- IF/ID update follows the same priority:
  - Flush (exc_i or branch_taken_i): instr <= 0, pc <= 0, valid <= 0.
  - Stall only: all IF/ID fields hold, valid included.
  - Normal: pc <= pc_o, instr <= imem_q_i, valid <= 1.
- Simultaneous events:
  - Flush beats stall: the stalled wrong-path instruction is discarded.
  - Exception beats branch: the vector wins and the branch target is dropped.
- fetch_count_o increments by 1 on each normal load only. It does not count on stall or flush, and wraps modulo 2^CNT_W.
- No combinational path from stall_i, branch_taken_i or exc_i to imem_addr_o; the redirect takes effect on the next edge.
- The first cycle after reset release fetches RESET_PC. IF/ID becomes valid after the first rising edge with reset low.

Decomposition:
- Package fetch_pkg:
  - constants: INSTR_W=32, BUBBLE_INSTR=32'h0, default RESET_PC, default EXC_VECTOR
  - typedef next_pc_sel_e {SEL_SEQ, SEL_HOLD, SEL_BRANCH, SEL_EXC}
  - packed struct if_id_t {pc, instr, valid}
- Sub-module if_id_reg: async-reset register with enable (= !stall or flush) and synchronous clear (= flush), carrying if_id_t.
- PC register, adder and next-PC mux stay in fetch_stage.

Test Plan:
1. Reset then 4 idle cycles, ROM word0=32'hf8000001, word1=32'hf8008002:
   - pc_o steps 0,4,8,C,10.
   - if_id_instr_o is f8000001 then f8008002.
   - valid=1 from the first edge; fetch_count_o=4.
2. stall_i high 2 cycles at pc_o=8:
   - pc_o stays 8.
   - if_id_pc_o stays 4 and if_id_instr_o holds.
   - fetch_count_o frozen; resumes at pc_o=C after release.
3. branch_taken_i=1, branch_target_i=64'h3B at pc_o=10:
   - Next cycle pc_o=38 and IF/ID is a bubble (instr=0, valid=0).
   - Following cycle if_id_pc_o=38.
4. exc_i, branch_taken_i (target 64'h40) and stall_i all high in one cycle:
   - pc_o=D8, IF/ID flushed, fetch_count_o unchanged.
5. Run to pc_o=1FC, no redirect:
   - Next pc_o=200 and imem_addr_o=0.
   - if_id_instr_o equals ROM word 127 then word 0.
6. Assert reset mid-stream at pc_o=24 between clock edges:
   - All outputs go to their reset values immediately, without a clock edge.
   - Fetch restarts at RESET_PC on release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 64;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 64'h0;
  localparam logic [PC_W-1:0] DEF_EXC_VECTOR = 64'hD8;

  typedef enum logic [1:0] {SEL_SEQ, SEL_HOLD, SEL_BRANCH, SEL_EXC} next_pc_sel_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: async reset, synchronous clear (flush) beats enable.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   clr,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
    end else if (clr) begin
      q <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC register, next-PC selection, ROM addressing and IF/ID capture.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              N          = 64,
  parameter int              IMEM_AW    = 7,
  parameter logic [N-1:0]    RESET_PC   = DEF_RESET_PC[N-1:0],
  parameter logic [N-1:0]    EXC_VECTOR = DEF_EXC_VECTOR[N-1:0],
  parameter int              CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [N-1:0]       branch_target_i,
  input  logic               exc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [INSTR_W-1:0] imem_q_i,
  output logic [N-1:0]       pc_o,
  output logic [N-1:0]       if_id_pc_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic               if_id_valid_o,
  output logic [CNT_W-1:0]   fetch_count_o
);

  next_pc_sel_e sel;
  logic [N-1:0] pc_p0;
  logic [N-1:0] branch_pc;
  logic [CNT_W-1:0] count;
  logic flush;
  if_id_t if_id_d;
  if_id_t if_id_q;

  // Exception outranks branch, and any redirect outranks stall.
  always_comb begin
    sel = SEL_SEQ;
    if (exc_i)               sel = SEL_EXC;
    else if (branch_taken_i) sel = SEL_BRANCH;
    else if (stall_i)        sel = SEL_HOLD;
  end

  // Word-align the target by masking; misaligned targets are not a fault.
  assign branch_pc = branch_target_i & ~N'(3);
  assign flush     = exc_i | branch_taken_i;

  // Stage p0: fetch PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else begin
      unique case (sel)
        SEL_EXC:    pc_p0 <= EXC_VECTOR;
        SEL_BRANCH: pc_p0 <= branch_pc;
        SEL_HOLD:   pc_p0 <= pc_p0;
        default:    pc_p0 <= pc_p0 + N'(4);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (sel == SEL_SEQ) begin
      count <= count + CNT_W'(1);
    end
  end

  assign if_id_d = '{pc: PC_W'(pc_p0), instr: imem_q_i, valid: 1'b1};

  // Stage p1: IF/ID register
  if_id_reg u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_i | flush),
    .clr   (flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign pc_o          = pc_p0;
  assign imem_addr_o   = pc_p0[IMEM_AW+1:2];
  assign if_id_pc_o    = if_id_q.pc[N-1:0];
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;
  assign fetch_count_o = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed plan steps plus randomized redirects/stalls.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, branch_taken_i, exc_i;
  logic [63:0] branch_target_i;
  logic [6:0]  imem_addr_o;
  logic [31:0] imem_q_i;
  logic [63:0] pc_o, if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [31:0] fetch_count_o;

  logic [31:0] rom [128];

  typedef struct {
    logic [63:0] pc;
    logic [63:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  assign imem_q_i = rom[imem_addr_o];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .exc_i           (exc_i),
    .imem_addr_o     (imem_addr_o),
    .imem_q_i        (imem_q_i),
    .pc_o            (pc_o),
    .if_id_pc_o      (if_id_pc_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o),
    .fetch_count_o   (fetch_count_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int rom_index(input logic [63:0] pc);
    return int'((pc / 64'd4) % 64'd128);
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
  endtask

  // Drive one cycle from a negedge, predict the post-edge state, return at the next negedge.
  task automatic cycle(input logic st, input logic br, input logic ex, input logic [63:0] tgt);
    exp_t e;
    stall_i = st; branch_taken_i = br; exc_i = ex; branch_target_i = tgt;
    if (ex || br) begin
      m_pc = ex ? 64'hD8 : (tgt - (tgt % 64'd4));
      m_ipc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_ipc = m_pc;
      m_instr = rom[rom_index(m_pc)];
      m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
      m_pc = m_pc + 64'd4;
    end
    e = '{pc: m_pc, ipc: m_ipc, instr: m_instr, valid: m_valid, cnt: m_cnt};
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc_o, 64'h0);
    chk({tag, "_ifid_pc"}, if_id_pc_o, 64'h0);
    chk({tag, "_ifid_instr"}, {32'h0, if_id_instr_o}, 64'h0);
    chk({tag, "_ifid_valid"}, {63'h0, if_id_valid_o}, 64'h0);
    chk({tag, "_count"}, {32'h0, fetch_count_o}, 64'h0);
  endtask

  // Raise reset between clock edges, check immediately, release on a later negedge.
  task automatic mid_reset(input string tag);
    stall_i = 1'b0; branch_taken_i = 1'b0; exc_i = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compare every output just after each active edge against the queued prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_pc", pc_o, e.pc);
      chk("sb_imem_addr", {57'h0, imem_addr_o}, 64'(rom_index(e.pc)));
      chk("sb_ifid_pc", if_id_pc_o, e.ipc);
      chk("sb_ifid_instr", {32'h0, if_id_instr_o}, {32'h0, e.instr});
      chk("sb_ifid_valid", {63'h0, if_id_valid_o}, {63'h0, e.valid});
      chk("sb_count", {32'h0, fetch_count_o}, {32'h0, e.cnt});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_cnt;
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0] = 32'hf8000001;
    rom[1] = 32'hf8008002;
    reset = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0; exc_i = 1'b0; branch_target_i = 64'h0;
    model_reset();
    #3 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Plan 1: sequential fetch
    idle(1);
    chk("t1_instr0", {32'h0, if_id_instr_o}, 64'hf8000001);
    chk("t1_valid", {63'h0, if_id_valid_o}, 64'h1);
    idle(1);
    chk("t1_instr1", {32'h0, if_id_instr_o}, 64'hf8008002);
    idle(2);
    chk("t1_pc", pc_o, 64'h10);
    chk("t1_count", {32'h0, fetch_count_o}, 64'd4);

    // Plan 2: stall at pc 8
    mid_reset("rst2");
    idle(2);
    chk("t2_pc_pre", pc_o, 64'h8);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    chk("t2_pc_hold", pc_o, 64'h8);
    chk("t2_ifid_pc_hold", if_id_pc_o, 64'h4);
    chk("t2_count_hold", {32'h0, fetch_count_o}, 64'd2);
    idle(1);
    chk("t2_pc_resume", pc_o, 64'hC);

    // Plan 3: branch to misaligned target
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 64'h3B);
    chk("t3_pc", pc_o, 64'h38);
    chk("t3_bubble_valid", {63'h0, if_id_valid_o}, 64'h0);
    chk("t3_bubble_instr", {32'h0, if_id_instr_o}, 64'h0);
    idle(1);
    chk("t3_ifid_pc", if_id_pc_o, 64'h38);

    // Plan 4: exception + branch + stall together
    saved_cnt = fetch_count_o;
    cycle(1'b1, 1'b1, 1'b1, 64'h40);
    chk("t4_pc", pc_o, 64'hD8);
    chk("t4_flush", {63'h0, if_id_valid_o}, 64'h0);
    chk("t4_count", {32'h0, fetch_count_o}, {32'h0, saved_cnt});

    // Plan 5: ROM aliasing at 0x200
    cycle(1'b0, 1'b1, 1'b0, 64'h1F0);
    idle(3);
    chk("t5_pc_1fc", pc_o, 64'h1FC);
    idle(1);
    chk("t5_pc_200", pc_o, 64'h200);
    chk("t5_addr_0", {57'h0, imem_addr_o}, 64'h0);
    chk("t5_instr_w127", {32'h0, if_id_instr_o}, {32'h0, rom[127]});
    idle(1);
    chk("t5_instr_w0", {32'h0, if_id_instr_o}, 64'hf8000001);

    // Plan 6: asynchronous reset mid-stream at pc 0x24
    cycle(1'b0, 1'b1, 1'b0, 64'h10);
    idle(5);
    chk("t6_pc_pre", pc_o, 64'h24);
    mid_reset("rst6");
    idle(1);
    chk("t6_restart_ifid_pc", if_id_pc_o, 64'h0);
    chk("t6_restart_pc", pc_o, 64'h4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic st, br, ex;
      logic [63:0] tgt;
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 9) == 0);
      ex = ($urandom_range(0, 24) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 32'h7FF));
      if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
      else cycle(st, br, ex, tgt);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
